// File: rtl/hydra_tx_pkg.sv
// Shared types for the hydra switch per-port transmitter.
package hydra_tx_pkg;

    localparam int LEN_W  = 9;
    localparam int PRIO_W = 3;
    localparam int DEST_W = 4;

    typedef struct packed {
        logic [LEN_W-1:0]  len;
        logic [PRIO_W-1:0] prio;
        logic [DEST_W-1:0] dest;
    } pkt_hdr_t;

    typedef enum logic [2:0] {
        IDLE,
        SOP,
        HDR,
        DATA,
        EOP,
        GAP
    } tx_state_t;

endpackage

// File: rtl/port_pkt_tx.sv
// Frames a descriptor plus payload stream onto one hydra switch write port.
module port_pkt_tx
    import hydra_tx_pkg::*;
#(
    parameter int DW      = 16,
    parameter int GAP_CYC = 0,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              desc_valid,
    output logic              desc_ready,
    input  logic [LEN_W-1:0]  desc_len,
    input  logic [PRIO_W-1:0] desc_prio,
    input  logic [DEST_W-1:0] desc_dest,
    input  logic              pl_valid,
    output logic              pl_ready,
    input  logic [DW-1:0]     pl_data,
    input  logic              pause,
    output logic              wr_sop,
    output logic              wr_vld,
    output logic [DW-1:0]     wr_data,
    output logic              wr_eop,
    output logic              busy,
    output logic              len_err,
    output logic [CNT_W-1:0]  pkt_cnt
);

    localparam logic [3:0] GAP_LD = 4'(GAP_CYC);

    tx_state_t         state_q, state_d;
    pkt_hdr_t          hdr_q, hdr_d;
    logic [LEN_W-1:0]  remain_q, remain_d;
    logic [3:0]        gap_q, gap_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_sop_q, wr_sop_d;
    logic              wr_vld_q, wr_vld_d;
    logic              wr_eop_q, wr_eop_d;
    logic [DW-1:0]     wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              len_err_q, len_err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            hdr_q     <= '0;
            remain_q  <= '0;
            gap_q     <= '0;
            cnt_q     <= '0;
            wr_sop_q  <= 1'b0;
            wr_vld_q  <= 1'b0;
            wr_eop_q  <= 1'b0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hdr_q     <= hdr_d;
            remain_q  <= remain_d;
            gap_q     <= gap_d;
            cnt_q     <= cnt_d;
            wr_sop_q  <= wr_sop_d;
            wr_vld_q  <= wr_vld_d;
            wr_eop_q  <= wr_eop_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            len_err_q <= len_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hdr_d      = hdr_q;
        remain_d   = remain_q;
        gap_d      = gap_q;
        cnt_d      = cnt_q;
        wr_sop_d   = 1'b0;
        wr_vld_d   = 1'b0;
        wr_eop_d   = 1'b0;
        wr_data_d  = wr_data_q;
        len_err_d  = 1'b0;
        desc_ready = 1'b0;
        pl_ready   = 1'b0;

        if (gap_q != 4'd0) begin
            gap_d = gap_q - 4'd1;
        end

        unique case (state_q)
            IDLE: begin
                desc_ready = !pause && (gap_q == 4'd0);
                if (desc_valid && desc_ready) begin
                    if (desc_len == '0) begin
                        len_err_d = 1'b1;
                    end else begin
                        hdr_d    = '{len: desc_len, prio: desc_prio, dest: desc_dest};
                        remain_d = desc_len;
                        wr_sop_d = 1'b1;
                        state_d  = SOP;
                    end
                end
            end
            SOP: begin
                wr_vld_d  = 1'b1;
                wr_data_d = hdr_q;
                state_d   = HDR;
            end
            HDR, DATA: begin
                pl_ready = 1'b1;
                state_d  = DATA;
                // an empty payload slot becomes a wr_vld=0 bubble
                if (pl_valid) begin
                    wr_vld_d  = 1'b1;
                    wr_data_d = pl_data;
                    remain_d  = remain_q - 1'b1;
                    if (remain_q == 9'd1) begin
                        state_d = EOP;
                    end
                end
            end
            EOP: begin
                wr_eop_d = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                gap_d    = GAP_LD;
                state_d  = (GAP_LD == 4'd0) ? IDLE : GAP;
            end
            GAP: begin
                if (gap_q <= 4'd1) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = wr_eop_d ||
                 (state_d == SOP) || (state_d == HDR) ||
                 (state_d == DATA) || (state_d == EOP);
    end

    assign wr_sop  = wr_sop_q;
    assign wr_vld  = wr_vld_q;
    assign wr_eop  = wr_eop_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign len_err = len_err_q;
    assign pkt_cnt = cnt_q;

endmodule
